// File: rtl/seg7_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode_if
// Purpose  : Bundles the segment input, digit handshake and word/status
//            outputs of seg7_decode into one interface.
// Signals  : seg_in[6:0]  active-low segments, [6]=a .. [0]=g
//            seg_valid    seg_in meaningful this cycle
//            digit[3:0]   decoded hex value
//            digit_valid  digit holds an unconsumed value
//            digit_ready  consumer accepts digit
//            word[15:0]   consumed digits, newest in [3:0]
//            word_valid   one-cycle pulse when a full word is collected
//            err          one-cycle pulse on acceptance of an illegal pattern
//            overrun      sticky: a legal digit was dropped
// Modports : master = producer/consumer side, slave = seg7_decode
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_decode_if;
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        digit_ready;
  logic [15:0] word;
  logic        word_valid;
  logic        err;
  logic        overrun;

  modport master (
    output seg_in, seg_valid, digit_ready,
    input  digit, digit_valid, word, word_valid, err, overrun
  );

  modport slave (
    input  seg_in, seg_valid, digit_ready,
    output digit, digit_valid, word, word_valid, err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Debounces a 7-segment pattern stream, decodes accepted patterns
//            to hex digits, offers them on a valid/ready handshake and
//            assembles consumed digits into a 16-bit word.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - seg7_decode_if.slave (segment input, digit handshake,
//                     word, err, overrun)
// Params   : STABLE_CYCLES (1..255) identical valid samples to accept
//            WORD_DIGITS   (1..4)   consumed digits per word_valid pulse
// Options  : SEG7_DECODE_ALT_GLYPH_EN - also decode 0001101 as 7 and
//            0001100 as 9 (illegal otherwise)
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode #(
  parameter int STABLE_CYCLES = 4,
  parameter int WORD_DIGITS   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_decode_if.slave  bus
);

  localparam logic [6:0] c_BLANK  = 7'b1111111;
  localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);
  localparam logic [2:0] c_WORDN  = 3'(WORD_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_cand,  w_cand_nxt;
  logic [7:0]  r_count, w_count_nxt;
  logic [7:0]  w_count_inc;
  logic        w_sample_ok;
  logic        w_same;
  logic        w_accept;
  logic [4:0]  w_dec;
  logic        w_legal;
  logic [3:0]  w_value;
  logic        w_hs;

  logic [3:0]  r_digit;
  logic        r_digit_valid;
  logic [15:0] r_word;
  logic [2:0]  r_wcnt;
  logic        r_word_valid;
  logic        r_err;
  logic        r_overrun;

  // {legal, value}; anything not listed is illegal
  function automatic logic [4:0] f_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
`ifdef SEG7_DECODE_ALT_GLYPH_EN
      7'b0001101: r = 5'h17;
      7'b0001100: r = 5'h19;
`endif
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign w_sample_ok = bus.seg_valid && (bus.seg_in != c_BLANK);
  assign w_same      = (bus.seg_in == r_cand);
  assign w_count_inc = r_count + 8'd1;
  assign w_dec       = f_decode(bus.seg_in);
  assign w_legal     = w_dec[4];
  assign w_value     = w_dec[3:0];
  assign w_hs        = r_digit_valid && bus.digit_ready;

  // ---------------------------------------------------------------- filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cand  <= 7'd0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    if (!w_sample_ok) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = 8'd0;
    end else begin
      case (r_state)
        S_TRACK: begin
          if (w_same) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == c_STABLE) begin
              w_accept    = 1'b1;
              w_state_nxt = S_LOCKED;
            end
          end else begin
            w_cand_nxt  = bus.seg_in;
            w_count_nxt = 8'd1;
            w_accept    = (c_STABLE == 8'd1);
            w_state_nxt = (c_STABLE == 8'd1) ? S_LOCKED : S_TRACK;
          end
        end
        S_LOCKED: begin
          if (!w_same) begin
            w_cand_nxt  = bus.seg_in;
            w_count_nxt = 8'd1;
            w_accept    = (c_STABLE == 8'd1);
            w_state_nxt = (c_STABLE == 8'd1) ? S_LOCKED : S_TRACK;
          end
        end
        default: begin
          // IDLE: a fresh candidate; a single required sample accepts at once
          w_cand_nxt  = bus.seg_in;
          w_count_nxt = 8'd1;
          w_accept    = (c_STABLE == 8'd1);
          w_state_nxt = (c_STABLE == 8'd1) ? S_LOCKED : S_TRACK;
        end
      endcase
    end
  end

  // ------------------------------------------------- digit, word and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_word        <= 16'd0;
      r_wcnt        <= 3'd0;
      r_word_valid  <= 1'b0;
      r_err         <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_err        <= w_accept && !w_legal;
      r_word_valid <= 1'b0;

      // A new acceptance may replace the digit only if the slot is free or
      // being consumed on this same edge; otherwise it is dropped.
      if (w_accept && w_legal) begin
        if (!r_digit_valid || bus.digit_ready) begin
          r_digit       <= w_value;
          r_digit_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_digit_valid <= 1'b0;
      end

      if (w_hs) begin
        r_word <= {r_word[11:0], r_digit};
        if (r_wcnt + 3'd1 == c_WORDN) begin
          r_wcnt       <= 3'd0;
          r_word_valid <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 3'd1;
        end
      end
    end
  end

  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_digit_valid;
  assign bus.word        = r_word;
  assign bus.word_valid  = r_word_valid;
  assign bus.err         = r_err;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_decode
// Purpose  : Self-checking bench for seg7_decode. A reference model decides
//            acceptance from a sliding window of recent samples and tracks
//            the digit slot, word and status flags; directed scenarios are
//            followed by randomized segment streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_decode;

  localparam int STABLE = 4;
  localparam int WD     = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_decode_if bus ();

  seg7_decode #(.STABLE_CYCLES(STABLE), .WORD_DIGITS(WD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [3:0]  m_digit;
  logic        m_dv, m_wv, m_err, m_ovr;
  logic [15:0] m_word;
  int          m_cnt;
  logic [7:0]  hist [$];   // {usable, pattern} per sampled cycle

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
`ifdef SEG7_DECODE_ALT_GLYPH_EN
    if (p == 7'b0001101) return 7;
    if (p == 7'b0001100) return 9;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_digit = 4'd0; m_dv = 1'b0; m_wv = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    m_word = 16'd0; m_cnt = 0;
    hist.delete();
  endtask

  // Accept when the newest STABLE samples are the same usable pattern and the
  // sample before that window is not (so a held pattern accepts only once).
  task automatic model_step(input logic [6:0] seg, input logic v, input logic rdy);
    logic [7:0] e;
    logic       acc, hs;
    logic [3:0] old;
    int         d;
    e = {v && (seg != BLANK), seg};
    hist.push_back(e);
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
    acc = 1'b0;
    if (hist.size() >= STABLE) begin
      acc = e[7];
      for (int i = hist.size() - STABLE; i < hist.size(); i++)
        if (hist[i] != e) acc = 1'b0;
      if (hist.size() > STABLE && hist[0] == e) acc = 1'b0;
    end
    hs  = m_dv && rdy;
    old = m_digit;
    d   = acc ? decode(seg) : -1;
    m_err = acc && (d < 0);
    if (acc && d >= 0) begin
      if (!m_dv || rdy) begin m_digit = d[3:0]; m_dv = 1'b1; end
      else m_ovr = 1'b1;
    end else if (hs) begin
      m_dv = 1'b0;
    end
    m_wv = 1'b0;
    if (hs) begin
      m_word = {m_word[11:0], old};
      m_cnt++;
      if (m_cnt == WD) begin m_cnt = 0; m_wv = 1'b1; end
    end
  endtask

  task automatic compare_all();
    chk("digit",       32'(bus.digit),       32'(m_digit));
    chk("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
    chk("word",        32'(bus.word),        32'(m_word));
    chk("word_valid",  32'(bus.word_valid),  32'(m_wv));
    chk("err",         32'(bus.err),         32'(m_err));
    chk("overrun",     32'(bus.overrun),     32'(m_ovr));
  endtask

  task automatic step(input logic [6:0] seg, input logic v, input logic rdy);
    @(negedge clk);
    bus.seg_in = seg; bus.seg_valid = v; bus.digit_ready = rdy;
    @(posedge clk);
    #1;
    model_step(seg, v, rdy);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    bus.seg_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    int dvs, errs, wvs;
    logic [15:0] wcap;
    logic [6:0]  pat;
    int          sel, len;
    logic        v;

    bus.seg_in = BLANK; bus.seg_valid = 1'b0; bus.digit_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single digit 5 with ready held high
    for (int i = 1; i <= 4; i++) begin
      step(7'b0100100, 1'b1, 1'b1);
      if (i == 3) chk("d5_early_dv", 32'(bus.digit_valid), 32'd0);
    end
    chk("d5_dv",    32'(bus.digit_valid), 32'd1);
    chk("d5_digit", 32'(bus.digit),       32'd5);
    step(BLANK, 1'b1, 1'b1);
    chk("d5_dv_drop", 32'(bus.digit_valid), 32'd0);

    // alternating patterns never reach the threshold
    dvs = 0; errs = 0;
    for (int i = 0; i < 3; i++) begin
      step(7'b0000110, 1'b1, 1'b1); dvs += int'(bus.digit_valid); errs += int'(bus.err);
    end
    for (int i = 0; i < 3; i++) begin
      step(7'b1001111, 1'b1, 1'b1); dvs += int'(bus.digit_valid); errs += int'(bus.err);
    end
    chk("alt_no_dv",  32'(dvs),  32'd0);
    chk("alt_no_err", 32'(errs), 32'd0);

    // pending A blocks a later 8 -> overrun
    repeat (4) step(7'b0001000, 1'b1, 1'b0);
    chk("ovr_a_dv", 32'(bus.digit_valid), 32'd1);
    step(BLANK, 1'b1, 1'b0);
    repeat (4) step(7'b0000000, 1'b1, 1'b0);
    chk("ovr_digit", 32'(bus.digit),       32'hA);
    chk("ovr_dv",    32'(bus.digit_valid), 32'd1);
    chk("ovr_flag",  32'(bus.overrun),     32'd1);

    // reset mid-TRACK with a digit still pending
    repeat (2) step(7'b0000110, 1'b1, 1'b0);
    do_reset();
    chk("rst_dv",   32'(bus.digit_valid), 32'd0);
    chk("rst_ovr",  32'(bus.overrun),     32'd0);
    chk("rst_word", 32'(bus.word),        32'd0);
    dvs = 0; errs = 0;
    for (int i = 0; i < 2; i++) begin
      step(7'b0000110, 1'b1, 1'b1); dvs += int'(bus.digit_valid); errs += int'(bus.err);
    end
    chk("rst_no_acc", 32'(dvs),  32'd0);
    chk("rst_no_err", 32'(errs), 32'd0);
    step(BLANK, 1'b1, 1'b1);

    // word assembly 1,2,3,4
    wvs = 0; wcap = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      pat = codes[k];
      for (int i = 0; i < 4; i++) begin
        step(pat, 1'b1, 1'b1);
        if (bus.word_valid) begin wvs++; wcap = bus.word; end
      end
      step(BLANK, 1'b1, 1'b1);
      if (bus.word_valid) begin wvs++; wcap = bus.word; end
    end
    step(BLANK, 1'b1, 1'b1);
    if (bus.word_valid) wvs++;
    chk("word_pulses", 32'(wvs),  32'd1);
    chk("word_value",  32'(wcap), 32'h1234);

    // illegal pattern
    repeat (4) step(7'b1111110, 1'b1, 1'b1);
    chk("ill_err", 32'(bus.err),         32'd1);
    chk("ill_dv",  32'(bus.digit_valid), 32'd0);
    step(7'b1111110, 1'b1, 1'b1);
    chk("ill_err_once", 32'(bus.err), 32'd0);
    step(BLANK, 1'b1, 1'b1);

    // alternate glyph for 7
    repeat (4) step(7'b0001101, 1'b1, 1'b1);
`ifdef SEG7_DECODE_ALT_GLYPH_EN
    chk("alt7_digit", 32'(bus.digit),       32'd7);
    chk("alt7_dv",    32'(bus.digit_valid), 32'd1);
`else
    chk("alt7_err", 32'(bus.err),         32'd1);
    chk("alt7_dv",  32'(bus.digit_valid), 32'd0);
`endif
    step(BLANK, 1'b1, 1'b1);

    // randomized segment streams
    for (int s = 0; s < 600; s++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      pat = codes[$urandom_range(0, 15)];
      else if (sel == 6) pat = BLANK;
      else if (sel == 7) pat = ($urandom_range(0, 1) == 0) ? 7'b0001101 : 7'b0001100;
      else               pat = 7'($urandom);
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) begin
        v = ($urandom_range(0, 9) != 0);
        step(pat, v, 1'($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
